// File: rtl/uart_tx_fifo_if.sv
// Write-side and uart-handshake signal bundle for uart_tx_fifo.
// cts_n is present only when UART_TX_CTS_EN is defined.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                clr_overflow;
  logic                uart_transmit;
  logic [7:0]          uart_tx_byte;
  logic                uart_busy;
`ifdef UART_TX_CTS_EN
  logic                cts_n;
`endif

  modport master (
    output wr_en, output wr_data, output clr_overflow, output uart_busy,
`ifdef UART_TX_CTS_EN
    output cts_n,
`endif
    input  full, input empty, input level, input overflow,
    input  uart_transmit, input uart_tx_byte
  );

  modport slave (
    input  wr_en, input wr_data, input clr_overflow, input uart_busy,
`ifdef UART_TX_CTS_EN
    input  cts_n,
`endif
    output full, output empty, output level, output overflow,
    output uart_transmit, output uart_tx_byte
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO draining one byte at a time into the uart transmit handshake.
// Optional feature macro: UART_TX_CTS_EN (gate byte start on cts_n == 0).
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_MAX  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r, level_nxt_s;
  logic                  full_r, empty_r, overflow_r, transmit_r;
  logic [7:0]            tx_byte_r;
  logic                  cts_ok_s, push_s, drop_s, pop_s;

`ifdef UART_TX_CTS_EN
  assign cts_ok_s = ~bus.cts_n;
`else
  assign cts_ok_s = 1'b1;
`endif
  // full is the registered pre-edge value, so a push while full drops even if a pop coincides
  assign push_s = bus.wr_en & ~full_r;
  assign drop_s = bus.wr_en & full_r;

  // Handshake sequencing; a byte is popped only when leaving IDLE
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_r && !bus.uart_busy && cts_ok_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE:     state_nxt_s = WAIT_BUSY;
      WAIT_BUSY: state_nxt_s = bus.uart_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_nxt_s = bus.uart_busy ? WAIT_DONE : IDLE;
      default:   state_nxt_s = IDLE;
    endcase
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LEVEL_ONE;
      2'b01:   level_nxt_s = level_r - LEVEL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, flags, FSM state and the registered uart strobe/byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      level_r    <= LEVEL_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      transmit_r <= 1'b0;
      tx_byte_r  <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      level_r    <= level_nxt_s;
      full_r     <= (level_nxt_s == LEVEL_MAX);
      empty_r    <= (level_nxt_s == LEVEL_ZERO);
      transmit_r <= pop_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        tx_byte_r <= mem_r[rd_ptr_r];
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Byte storage; stale contents after reset are never read
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  assign bus.full          = full_r;
  assign bus.empty         = empty_r;
  assign bus.level         = level_r;
  assign bus.overflow      = overflow_r;
  assign bus.uart_transmit = transmit_r;
  assign bus.uart_tx_byte  = tx_byte_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: queue-based reference model plus a simple uart busy model.
module tb_uart_tx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus_if ();
  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: pending bytes in order, plus where the uart handshake stands
  logic [7:0] q[$];
  logic [7:0] sent[$];
  bit         m_ovf, m_pulse;
  logic [7:0] m_byte;
  int         m_hs;         // 0 ready, 1 strobe out, 2 awaiting busy rise, 3 awaiting busy fall
  bit         edge_busy, prev_busy;
  int         cyc, fall_edge;
  bit         gap_chk;

  // uart model
  bit force_busy, busy_start;
  int busy_len, busy_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int lvl;
    bit b, cts_ok, go;
    lvl = q.size();
    b   = bus_if.uart_busy;
`ifdef UART_TX_CTS_EN
    cts_ok = !bus_if.cts_n;
`else
    cts_ok = 1'b1;
`endif
    edge_busy = b;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_pulse = 0; m_byte = 8'h00; m_hs = 0;
    end else begin
      go = (m_hs == 0) && (lvl > 0) && !b && cts_ok;
      if (bus_if.wr_en && lvl == DEPTH) m_ovf = 1;
      else if (bus_if.clr_overflow) m_ovf = 0;
      if (go) begin
        m_byte = q.pop_front(); m_pulse = 1; m_hs = 1;
      end else begin
        m_pulse = 0;
        if (m_hs == 1) m_hs = 2;
        else if (m_hs == 2 && b) m_hs = 3;
        else if (m_hs == 3 && !b) m_hs = 0;
      end
      if (bus_if.wr_en && lvl < DEPTH) q.push_back(bus_if.wr_data);
      if (prev_busy && !b) fall_edge = cyc;
    end
    prev_busy = b;
  endtask

  task automatic compare();
    check_val("level", 32'(bus_if.level), 32'(q.size()));
    check_val("full", 32'(bus_if.full), 32'(q.size() == DEPTH));
    check_val("empty", 32'(bus_if.empty), 32'(q.size() == 0));
    check_val("overflow", 32'(bus_if.overflow), 32'(m_ovf));
    check_val("transmit", 32'(bus_if.uart_transmit), 32'(m_pulse));
    check_val("tx_byte", 32'(bus_if.uart_tx_byte), 32'(m_byte));
    if (bus_if.uart_transmit) begin
      sent.push_back(bus_if.uart_tx_byte);
      check_val("pulse_while_busy", 32'(edge_busy), 32'd0);
      if (gap_chk && fall_edge >= 0) check_val("gap_after_busy_fall", 32'(cyc - fall_edge), 32'd1);
    end
  endtask

  task automatic uart_model();
    if (force_busy) begin
      bus_if.uart_busy = 1'b1;
    end else if (busy_start) begin
      bus_if.uart_busy = 1'b1; busy_cnt = busy_len; busy_start = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) bus_if.uart_busy = 1'b0;
    end
    if (bus_if.uart_transmit) busy_start = 1;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare();
    uart_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.wr_en = 1'b0; bus_if.wr_data = 8'h00; bus_if.clr_overflow = 1'b0;
    bus_if.uart_busy = 1'b0;
`ifdef UART_TX_CTS_EN
    bus_if.cts_n = 1'b0;
`endif
    force_busy = 0; busy_start = 0; busy_cnt = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus_if.wr_en = 1'b1; bus_if.wr_data = d;
    step();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      if (q.size() == 0 && m_hs == 0 && busy_cnt == 0 && !busy_start && !bus_if.uart_busy) done = 1;
      else step();
    end
    check_val("drain_bound", 32'(q.size() + m_hs), 32'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == 8'hEE) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  initial begin
    int ee_cnt;
    cyc = 0; fall_edge = -1; gap_chk = 0; busy_len = 5; prev_busy = 0;
    do_reset();
    check_val("rst_level", 32'(bus_if.level), 32'd0);
    check_val("rst_empty", 32'(bus_if.empty), 32'd1);
    check_val("rst_tx_byte", 32'(bus_if.uart_tx_byte), 32'h00);

    // single byte latency
    push(8'h41);
    check_val("t1_level_n1", 32'(bus_if.level), 32'd1);
    step();
    check_val("t1_pulse_n2", 32'(bus_if.uart_transmit), 32'd1);
    check_val("t1_byte_n2", 32'(bus_if.uart_tx_byte), 32'h41);
    step();
    check_val("t1_pulse_n3", 32'(bus_if.uart_transmit), 32'd0);
    check_val("t1_level_n3", 32'(bus_if.level), 32'd0);
    drain(200);

    // five bytes back-to-back against a 20-cycle uart
    do_reset();
    busy_len = 20; fall_edge = -1; gap_chk = 1; sent.delete();
    for (int i = 1; i <= 5; i++) push(8'(i));
    drain(400);
    gap_chk = 0;
    check_val("t2_count", 32'(sent.size()), 32'd5);
    for (int i = 0; i < sent.size(); i++) check_val("t2_order", 32'(sent[i]), 32'(i + 1));

    // fill with uart stuck busy, then overflow and clear
    do_reset();
    force_busy = 1; bus_if.uart_busy = 1'b1; sent.delete();
    for (int i = 0; i < DEPTH; i++) push(rand_byte());
    push(8'hEE);
    check_val("t3_full", 32'(bus_if.full), 32'd1);
    check_val("t3_level", 32'(bus_if.level), 32'd16);
    check_val("t3_overflow", 32'(bus_if.overflow), 32'd1);
    bus_if.clr_overflow = 1'b1; step(); bus_if.clr_overflow = 1'b0;
    check_val("t3_clr", 32'(bus_if.overflow), 32'd0);

    // push while full in the same cycle as a pop
    force_busy = 0; bus_if.uart_busy = 1'b0; busy_start = 0; busy_cnt = 0; busy_len = 2;
    push(8'hEE);
    check_val("t4_level", 32'(bus_if.level), 32'd15);
    check_val("t4_overflow", 32'(bus_if.overflow), 32'd1);
    check_val("t4_pulse", 32'(bus_if.uart_transmit), 32'd1);
    for (int k = 0; k < 20; k++) begin
      int burst;
      burst = $urandom_range(1, 6);
      for (int j = 0; j < burst; j++) push(rand_byte());
      repeat ($urandom_range(5, 40)) step();
    end
    drain(2000);
    ee_cnt = 0;
    foreach (sent[i]) if (sent[i] == 8'hEE) ee_cnt++;
    check_val("t3_ee_never_sent", 32'(ee_cnt), 32'd0);

    // reset in the middle of a byte
    do_reset();
    busy_len = 30;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    repeat (5) step();
    check_val("t5_level_pre", 32'(bus_if.level), 32'd3);
    check_val("t5_busy_pre", 32'(bus_if.uart_busy), 32'd1);
    do_reset();
    check_val("t5_level", 32'(bus_if.level), 32'd0);
    check_val("t5_empty", 32'(bus_if.empty), 32'd1);
    check_val("t5_transmit", 32'(bus_if.uart_transmit), 32'd0);
    check_val("t5_overflow", 32'(bus_if.overflow), 32'd0);
    busy_len = 4;
    push(8'h77);
    step();
    check_val("t5_pulse", 32'(bus_if.uart_transmit), 32'd1);
    check_val("t5_byte", 32'(bus_if.uart_tx_byte), 32'h77);
    drain(200);

`ifdef UART_TX_CTS_EN
    begin
      int pulses;
      bit seen;
      do_reset();
      bus_if.cts_n = 1'b1;
      pulses = 0;
      push(8'h55);
      repeat (100) begin
        step();
        if (bus_if.uart_transmit) pulses++;
      end
      check_val("t6_no_pulse_cts_high", 32'(pulses), 32'd0);
      check_val("t6_level_held", 32'(bus_if.level), 32'd1);
      bus_if.cts_n = 1'b0;
      seen = 0;
      for (int i = 0; i < 2 && !seen; i++) begin
        step();
        if (bus_if.uart_transmit) begin
          seen = 1;
          check_val("t6_byte", 32'(bus_if.uart_tx_byte), 32'h55);
        end
      end
      check_val("t6_pulse_seen", 32'(seen), 32'd1);
      drain(200);
    end
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus_if.wr_en        = ($urandom_range(0, 2) == 0);
      bus_if.wr_data      = 8'($urandom_range(0, 255));
      bus_if.clr_overflow = ($urandom_range(0, 15) == 0);
`ifdef UART_TX_CTS_EN
      bus_if.cts_n        = ($urandom_range(0, 7) == 0);
`endif
      if (busy_cnt == 0) busy_len = $urandom_range(1, 25);
      step();
    end
    bus_if.wr_en = 1'b0; bus_if.clr_overflow = 1'b0;
`ifdef UART_TX_CTS_EN
    bus_if.cts_n = 1'b0;
`endif
    drain(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
